fifo_reader: RTL and testbench

Read-side controller for the team's flip-flop FIFO (`fifo_flops`). It drains a programmed burst of words from the FIFO via its `pndng`/`pop` handshake and re-times them through a 2-entry output buffer. It then presents the words on a valid/ready stream to the downstream consumer. It is the consumer counterpart of the FIFO's push side and sits between the FIFO and any module that needs back-pressure-aware delivery.

---
 rtl/fifo_rd_pkg.sv | 12 +
 rtl/fifo_reader_if.sv | 23 ++
 rtl/out_buf2.sv | 55 +++++
 rtl/fifo_reader.sv | 99 +++++++++
 tb/tb_fifo_reader.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read-side controller.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } rd_state_t;

  localparam int unsigned RD_COUNT_W = 16;

endpackage

// File: rtl/fifo_reader_if.sv
// FIFO read handshake plus downstream valid/ready stream.
interface fifo_reader_if #(
  parameter int unsigned bits = 32
);

  logic            pndng;
  logic [bits-1:0] fifo_dout;
  logic            pop;
  logic            out_valid;
  logic [bits-1:0] out_data;
  logic            out_ready;

  modport master (
    input  pndng, fifo_dout, out_ready,
    output pop, out_valid, out_data
  );

  modport slave (
    output pndng, fifo_dout, out_ready,
    input  pop, out_valid, out_data
  );

endinterface

// File: rtl/out_buf2.sv
// Two-entry FIFO-ordered valid/ready buffer; head entry drives rd_data.
module out_buf2 #(
  parameter int unsigned bits = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [bits-1:0] wr_data,
  output logic            rd_valid,
  output logic [bits-1:0] rd_data,
  input  logic            rd_ready,
  output logic [1:0]      occ
);

  logic [bits-1:0] ent0;
  logic [bits-1:0] ent1;
  logic            rd_en;

  assign rd_valid = (occ != 2'd0);
  assign rd_data  = ent0;
  assign rd_en    = rd_valid && rd_ready;

  // Entry shift/fill and occupancy tracking; ent0 is always the head.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ  <= 2'd0;
      ent0 <= '0;
      ent1 <= '0;
    end else begin
      unique case ({wr_en, rd_en})
        2'b10: begin
          if (occ != 2'd2) begin
            if (occ == 2'd0) ent0 <= wr_data;
            else             ent1 <= wr_data;
            occ <= occ + 2'd1;
          end
        end
        2'b01: begin
          ent0 <= ent1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            ent0 <= wr_data;
          end else begin
            ent0 <= ent1;
            ent1 <= wr_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_reader.sv
// Drains a programmed burst from fifo_flops and re-times it onto a valid/ready stream.
module fifo_reader
  import fifo_rd_pkg::*;
#(
  parameter  int unsigned bits      = 32,
  parameter  int unsigned max_burst = 16,
  localparam int unsigned BL_W      = $clog2(max_burst + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  fifo_reader_if.master         bus,
  input  logic                  start,
  input  logic [BL_W-1:0]       burst_len,
  output logic                  busy,
  output logic                  done,
  output logic [RD_COUNT_W-1:0] rd_count
);

  rd_state_t       state_q;
  rd_state_t       state_d;
  logic [BL_W-1:0] rem_q;
  logic [BL_W-1:0] rem_d;
  logic [BL_W-1:0] bl_clamped;
  logic            done_d;
  logic            pop_c;
  logic            xfer;
  logic [1:0]      occ;

  assign bl_clamped = (burst_len > BL_W'(max_burst)) ? BL_W'(max_burst) : burst_len;
  assign busy       = (state_q != IDLE);
  assign xfer       = bus.out_valid && bus.out_ready;
  assign bus.pop    = pop_c;

  out_buf2 #(.bits(bits)) u_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (pop_c),
    .wr_data  (bus.fifo_dout),
    .rd_valid (bus.out_valid),
    .rd_data  (bus.out_data),
    .rd_ready (bus.out_ready),
    .occ      (occ)
  );

  // State, remaining-word counter and done pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      done    <= done_d;
    end
  end

  // Next-state, pop request and burst bookkeeping.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    pop_c   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (bl_clamped != '0) begin
            rem_d   = bl_clamped;
            state_d = DRAIN;
          end else begin
            state_d = FLUSH;
          end
        end
      end
      DRAIN: begin
        // Pop only with a word available, buffer room and burst words left.
        pop_c = !rst && bus.pndng && (occ < 2'd2) && (rem_q != '0);
        if (pop_c) begin
          rem_d = rem_q - BL_W'(1);
          if (rem_q == BL_W'(1)) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (occ == 2'd0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Downstream delivery counter; wraps naturally at its width.
  always_ff @(posedge clk) begin
    if (rst)       rd_count <= '0;
    else if (xfer) rd_count <= rd_count + RD_COUNT_W'(1);
  end

endmodule

// File: tb/tb_fifo_reader.sv
// Scoreboard bench for fifo_reader: queue-based FIFO and stream reference model.
`timescale 1ns/1ps
module tb_fifo_reader;

  localparam int unsigned BITS = 32;
  localparam int unsigned MAXB = 16;
  localparam int unsigned BL_W = $clog2(MAXB + 1);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [BL_W-1:0] burst_len = '0;
  logic            busy;
  logic            done;
  logic [15:0]     rd_count;

  fifo_reader_if #(.bits(BITS)) bus ();

  fifo_reader #(.bits(BITS), .max_burst(MAXB)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .start     (start),
    .burst_len (burst_len),
    .busy      (busy),
    .done      (done),
    .rd_count  (rd_count)
  );

  always #5 clk = ~clk;

  logic [31:0] fifo_q[$];
  logic [31:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          pops = 0;
  logic [31:0] pop_mask = '0;
  logic        pndng_en = 1'b1;
  int          xfers = 0;
  logic [15:0] cnt_base = '0;
  int          done_seen = 0;
  int          done_cyc = -1;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  bit          rand_mode = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive();
    bus.pndng     = pndng_en && (fifo_q.size() != 0);
    bus.fifo_dout = (fifo_q.size() != 0) ? fifo_q[0] : 32'hDEAD_BEEF;
  endtask

  // One clock: sample pop mid-cycle, then model the FIFO consuming its head.
  task automatic tick();
    logic p;
    @(negedge clk);
    p = bus.pop;
    @(posedge clk);
    #1;
    if (p) begin
      if (cyc >= 0 && cyc < 32) pop_mask[5'(cyc)] = 1'b1;
      pops++;
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
    end
    cyc++;
    if (rand_mode) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      pndng_en      = ($urandom_range(0, 3) != 0);
    end
    drive();
  endtask

  // Expected stream for a burst is simply the next min(len,MAXB) FIFO words.
  task automatic start_burst(input int len);
    int n;
    n = (len > int'(MAXB)) ? int'(MAXB) : len;
    for (int i = 0; i < n && i < fifo_q.size(); i++) exp_q.push_back(fifo_q[i]);
    burst_len = BL_W'(len);
    start     = 1'b1;
    cyc       = 0;
    pops      = 0;
    pop_mask  = '0;
    done_cyc  = -1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string name);
    int d0;
    int k;
    d0 = done_seen;
    k  = 0;
    while (done_seen == d0 && k < limit) begin
      tick();
      k++;
    end
    check({name, "_done_seen"}, 32'(done_seen != d0), 32'd1);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    exp_q.delete();
    cnt_base = '0;
    for (int i = 0; i < n; i++) tick();
    rst = 1'b0;
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back($urandom);
    drive();
  endtask

  // Scoreboard monitor: compares each downstream transfer and invariants.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst) begin
        check("pop_in_reset", 32'(bus.pop), 32'd0);
        xfers      = 0;
        prev_stall = 1'b0;
      end else begin
        check("rd_count", 32'(rd_count), 32'(16'(cnt_base + 16'(xfers))));
        if (bus.pop) check("pop_needs_pndng", 32'(bus.pndng), 32'd1);
        if (prev_stall) begin
          check("hold_valid", 32'(bus.out_valid), 32'd1);
          check("hold_data", bus.out_data, prev_data);
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %h expected no word", bus.out_data);
          end else begin
            check("out_data", bus.out_data, exp_q.pop_front());
          end
          xfers++;
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_data  = bus.out_data;
        if (done) begin
          done_seen++;
          done_cyc = cyc;
          check("done_busy", 32'(busy), 32'd0);
          check("done_drained", 32'(exp_q.size()), 32'd0);
        end
      end
    end
  endtask

  initial begin
    int d0;
    int n;
    int len;
    int pat[6];
    logic [31:0] w0;
    pat = '{1, 0, 0, 1, 0, 1};
    bus.out_ready = 1'b1;
    drive();
    fork
      monitor();
    join_none

    do_reset(3);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_valid", 32'(bus.out_valid), 32'd0);
    check("reset_data", bus.out_data, 32'd0);
    check("reset_done", 32'(done), 32'd0);

    // Basic burst of four preloaded words at full throughput.
    for (int i = 0; i < 4; i++) fifo_q.push_back(32'hA0 + 32'(i));
    drive();
    start_burst(4);
    check("basic_busy_c1", 32'(busy), 32'd1);
    wait_done(20, "basic");
    check("basic_pop_cycles", pop_mask, 32'h0000_001E);
    check("basic_done_cycle", 32'(done_cyc), 32'd7);
    check("basic_rd_count", 32'(rd_count), 32'd4);

    // Back-pressure: consumer stalled until cycle 10.
    bus.out_ready = 1'b0;
    push_words(5);
    w0 = fifo_q[0];
    start_burst(5);
    while (cyc < 10) tick();
    check("bp_pops", 32'(pops), 32'd2);
    check("bp_occ", 32'(dut.occ), 32'd2);
    check("bp_valid", 32'(bus.out_valid), 32'd1);
    check("bp_head", bus.out_data, w0);
    bus.out_ready = 1'b1;
    wait_done(40, "bp");
    check("bp_pops_total", 32'(pops), 32'd5);

    // Starvation: pndng gated 1,0,0,1,0,1 during DRAIN.
    push_words(3);
    d0 = done_seen;
    start_burst(3);
    for (int i = 0; i < 6; i++) begin
      pndng_en = pat[i][0];
      drive();
      tick();
    end
    pndng_en = 1'b1;
    drive();
    wait_done(20, "starve");
    check("starve_pop_cycles", pop_mask, 32'h0000_0052);
    for (int i = 0; i < 4; i++) tick();
    check("starve_done_once", 32'(done_seen - d0), 32'd1);

    // Zero-length burst: no pop even with words available.
    push_words(2);
    start_burst(0);
    wait_done(10, "zero");
    check("zero_done_cycle", 32'(done_cyc), 32'd2);
    check("zero_pops", 32'(pops), 32'd0);

    // Clamp: oversize request drains exactly max_burst words.
    push_words(20 - fifo_q.size());
    start_burst(31);
    wait_done(100, "clamp");
    check("clamp_pops", 32'(pops), 32'd16);
    check("clamp_left", 32'(fifo_q.size()), 32'd4);
    fifo_q.delete();
    drive();

    // Reset mid-burst after two pops.
    bus.out_ready = 1'b0;
    push_words(8);
    start_burst(8);
    while (cyc < 4) tick();
    check("rst_pops", 32'(pops), 32'd2);
    d0  = done_seen;
    rst = 1'b1;
    exp_q.delete();
    cnt_base = '0;
    tick();
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_rd_count", 32'(rd_count), 32'd0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("rst_no_done", 32'(done_seen - d0), 32'd0);
    start_burst(1);
    wait_done(20, "rst_after");
    check("rst_after_pops", 32'(pops), 32'd1);
    fifo_q.delete();
    drive();

    // Randomized bursts with random back-pressure and starvation.
    rand_mode = 1'b1;
    for (int b = 0; b < 25; b++) begin
      len = int'($urandom_range(0, 20));
      n   = (len > int'(MAXB)) ? int'(MAXB) : len;
      push_words(n + int'($urandom_range(0, 2)));
      start_burst(len);
      wait_done(600, "rand");
      check("rand_pops", 32'(pops), 32'(n));
    end
    rand_mode     = 1'b0;
    bus.out_ready = 1'b1;
    pndng_en      = 1'b1;
    fifo_q.delete();
    drive();
    for (int i = 0; i < 3; i++) tick();

    // Counter wrap from 0xFFFF on one more delivered word.
    force dut.rd_count = 16'hFFFF;
    cnt_base = 16'hFFFF - 16'(xfers);
    tick();
    release dut.rd_count;
    tick();
    check("wrap_preset", 32'(rd_count), 32'h0000_FFFF);
    push_words(1);
    start_burst(1);
    wait_done(20, "wrap");
    check("wrap_rd_count", 32'(rd_count), 32'd0);

    // start pulse during DRAIN must not reload the burst length.
    bus.out_ready = 1'b0;
    push_words(6);
    d0 = done_seen;
    start_burst(3);
    while (cyc < 3) tick();
    burst_len = BL_W'(5);
    start     = 1'b1;
    tick();
    start = 1'b0;
    tick();
    bus.out_ready = 1'b1;
    wait_done(40, "ign");
    check("ign_pops", 32'(pops), 32'd3);
    check("ign_fifo_left", 32'(fifo_q.size()), 32'd3);
    for (int i = 0; i < 3; i++) tick();
    check("ign_idle_valid", 32'(bus.out_valid), 32'd0);
    check("ign_done_once", 32'(done_seen - d0), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
